// File: rtl/uart_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_pkg
//   Shared definitions for the UART transmit path:
//     - tx_state_e : 3-bit FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//     - line-level constants (start bit, stop bit, idle level)
//     - parity-type constants (even / odd)
//     - calc_parity: folds the parity type into an XOR-reduced data word
// ---------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the XOR-reduction of the word; even parity sends it as-is,
    // odd parity sends its inverse.
    function automatic logic calc_parity(input logic data_xor, input logic par_typ);
        logic r_bit;
        case (par_typ)
            PAR_EVEN: r_bit = data_xor;
            PAR_ODD:  r_bit = ~data_xor;
            default:  r_bit = data_xor;
        endcase
        return r_bit;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Data-word shift register plus bit-index counter for the UART TX path.
//   Ports:
//     CLK      in   bit clock (rising edge)
//     RST      in   asynchronous, active-low reset
//     i_load   in   latch i_data and clear the bit index
//     i_shift  in   advance to the next data bit (ignored at the last bit)
//     i_data   in   parallel word (DATA_WIDTH)
//     o_bit0   out  bit currently at the LSB of the shift register
//     o_bit1   out  bit that becomes the LSB after the next shift
//     o_last   out  bit index is at DATA_WIDTH-1
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bit0,
    output logic                  o_bit1,
    output logic                  o_last
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  w_last;

    assign w_last = (r_cnt == LAST_IDX);

    // The counter saturates at the last index, so it never wraps.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift && !w_last) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_bit0 = r_shift[0];
    assign o_bit1 = r_shift[1];
    assign o_last = w_last;

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit controller: latches a word and its frame configuration,
//   then sends start bit, data LSB-first, optional parity bit, stop bit,
//   one bit per CLK cycle. Back-to-back frames are accepted in STOP.
//   Ports:
//     CLK         in   TX bit clock
//     RST         in   asynchronous, active-low reset
//     P_DATA      in   parallel word (DATA_WIDTH), sampled at accept
//     Data_Valid  in   request strobe, honoured in IDLE and STOP only
//     PAR_EN      in   1 = insert parity bit (sampled at accept)
//     PAR_TYP     in   1 = odd, 0 = even parity (sampled at accept)
//     TX_OUT      out  registered serial line, idles high
//     Busy        out  registered, high while a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e r_state;
    tx_state_e w_next_state;

    logic r_tx;
    logic r_busy;
    logic r_par_en;
    logic r_parity;

    logic w_accept;
    logic w_par_bit;
    logic w_shift;
    logic w_bit0;
    logic w_bit1;
    logic w_last;
    logic w_tx_next;
    logic w_busy_next;

    assign w_accept  = Data_Valid && ((r_state == ST_IDLE) || (r_state == ST_STOP));
    assign w_par_bit = calc_parity(^P_DATA, PAR_TYP);
    assign w_shift   = (r_state == ST_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (P_DATA),
        .o_bit0  (w_bit0),
        .o_bit1  (w_bit1),
        .o_last  (w_last)
    );

    // Frame configuration and parity are captured only at accept.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_par_en <= PAR_EN;
            r_parity <= w_par_bit;
        end
    end

    // State register; the outputs are registered alongside it so they
    // change on the same edge as the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_tx    <= IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (Data_Valid) w_next_state = ST_START;
            ST_START:  w_next_state = ST_DATA;
            ST_DATA: begin
                if (w_last) w_next_state = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: w_next_state = ST_STOP;
            ST_STOP:   w_next_state = Data_Valid ? ST_START : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: values for the cycle that the next state occupies.
    // Entering DATA from START sends bit 0 (not yet shifted); staying in
    // DATA sends the bit that the concurrent shift brings to the LSB.
    always_comb begin
        w_tx_next   = IDLE_LEVEL;
        w_busy_next = 1'b1;
        case (w_next_state)
            ST_IDLE: begin
                w_tx_next   = IDLE_LEVEL;
                w_busy_next = 1'b0;
            end
            ST_START:  w_tx_next = START_BIT;
            ST_DATA:   w_tx_next = (r_state == ST_START) ? w_bit0 : w_bit1;
            ST_PARITY: w_tx_next = r_parity;
            ST_STOP:   w_tx_next = STOP_BIT;
            default: begin
                w_tx_next   = IDLE_LEVEL;
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks;
    int errors;

    uart_tx_ctrl #(
        .DATA_WIDTH(8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected line sequence: bits[10] is the first bit on the line
    // (start bit), bits[10-k] is line cycle k.
    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        int unsigned len;
        logic [10:0] bits;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Present a word for exactly one accept edge.
    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
    endtask

    // Check every line cycle of a frame. With disturb set, a request for
    // 8'hFF plus config changes are injected during the data bits.
    task automatic run_frame(input string name, input logic [10:0] bits,
                             input int unsigned len, input bit disturb);
        for (int unsigned k = 0; k < len; k++) begin
            @(negedge CLK);
            chk($sformatf("%s_tx%0d", name, k), TX_OUT, bits[10-k]);
            chk($sformatf("%s_busy%0d", name, k), Busy, 1'b1);
            if (disturb && k == 3) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                PAR_TYP    = ~PAR_TYP;
                PAR_EN     = 1'b0;
            end
            if (disturb && k == 4) Data_Valid = 1'b0;
        end
    endtask

    task automatic chk_idle(input string name);
        @(negedge CLK);
        chk({name, "_idle_tx"}, TX_OUT, 1'b1);
        chk({name, "_idle_busy"}, Busy, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        vecs[0] = '{"even_A5",  8'hA5, 1'b1, 1'b0, 11, 11'b01010010101};
        vecs[1] = '{"odd_FF",   8'hFF, 1'b1, 1'b1, 11, 11'b01111111111};
        vecs[2] = '{"odd_01",   8'h01, 1'b1, 1'b1, 11, 11'b01000000001};
        vecs[3] = '{"nopar_3C", 8'h3C, 1'b0, 1'b0, 10, 11'b00011110010};
        vecs[4] = '{"odd_00",   8'h00, 1'b1, 1'b1, 11, 11'b00000000011};
        vecs[5] = '{"nopar_81", 8'h81, 1'b0, 1'b1, 10, 11'b01000000110};

        // Reset state
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_tx", TX_OUT, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        chk_idle("post_rst");

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            start_frame(vecs[i].data, vecs[i].pen, vecs[i].ptyp);
            run_frame(vecs[i].name, vecs[i].bits, vecs[i].len, 1'b0);
            chk_idle(vecs[i].name);
        end

        // Back-to-back: 55 then AA with Data_Valid held high, no parity
        @(negedge CLK);
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1 P_DATA = 8'hAA;
        run_frame("b2b_55", 11'b01010101010, 10, 1'b0);
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        run_frame("b2b_AA", 11'b00101010110, 10, 1'b0);
        chk_idle("b2b");

        // Ignored request and mid-frame config change on an 8'h0F even frame
        start_frame(8'h0F, 1'b1, 1'b0);
        run_frame("ign_0F", 11'b01111000001, 11, 1'b1);
        chk_idle("ign_first");
        chk_idle("ign_second");

        // Reset during bit 4 of an A5 frame
        start_frame(8'hA5, 1'b1, 1'b0);
        run_frame("rst_A5", 11'b01010010101, 6, 1'b0);
        #2 RST = 1'b0;
        #1;
        chk("midrst_tx", TX_OUT, 1'b1);
        chk("midrst_busy", Busy, 1'b0);
        @(negedge CLK);
        chk("midrst_hold_tx", TX_OUT, 1'b1);
        chk("midrst_hold_busy", Busy, 1'b0);
        RST = 1'b1;
        start_frame(8'h81, 1'b0, 1'b0);
        run_frame("after_rst_81", 11'b01000000110, 10, 1'b0);
        chk_idle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
